scene_frame_tx: RTL and testbench
=================================

SCENE_FRAME_TX -- requirements
Module: scene_frame_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clocks per UART bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_en  input  1  word write strobe into the frame buffer.
REQ-005 SHALL have port wr_addr  input  5  word index, 0..26.
REQ-006 SHALL have port wr_data  input  16  word value, Q8.8 or Q2.14 as the GPU register map defines.
REQ-007 SHALL have port start  input  1  single-cycle request to transmit one frame.
REQ-008 SHALL have port busy  output  1  high while a frame is in flight.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the last stop bit completes.
REQ-010 SHALL have port byte_idx  output  6  index (0..54) of the byte currently on the line.
REQ-011 SHALL have port tx  output  1  UART 8N1 serial line, idle high.

Function
REQ-012 SHALL hold a 27-word buffer: words 0..8 vertex x/y/z v0..v2, 9..11 normal, 12..14 light, 15..26 vp_00..vp_03, vp_10..vp_13, vp_30..vp_33.
REQ-013 SHALL emit a 55-byte frame indexed 0..54: word k<25 -> bytes 2k (low) and 2k+1 (high); byte 50 = pad 0x00; word 25 -> bytes 51/52; word 26 -> bytes 53/54.
REQ-014 SHALL serialise each byte as one start bit (0), eight data bits LSB first, one stop bit (1), each bit exactly CLKS_PER_BIT cycles.
REQ-015 SHALL send consecutive bytes back-to-back: a byte's start bit begins on the cycle after the previous stop bit ends.
REQ-016 SHALL use FSM states IDLE, START_BIT, DATA_BITS, STOP_BIT; IDLE->START_BIT on accepted start, START_BIT->DATA_BITS, DATA_BITS->STOP_BIT after bit 7, STOP_BIT->START_BIT if more bytes remain, else ->IDLE.
REQ-017 SHALL accept start only in IDLE; tx falls low on the cycle after start is sampled and busy rises on that same cycle.
REQ-018 SHALL complete a frame in exactly 55*10*CLKS_PER_BIT cycles from the first low tx cycle; done pulses and busy falls on the cycle after the final stop bit.
REQ-019 SHALL apply wr_en only in IDLE; writes while busy and writes with wr_addr >= 27 SHALL be ignored.
REQ-020 SHALL, when wr_en and start coincide in IDLE, commit the write first so the frame carries the new value.
REQ-021 SHALL ignore start while busy; no queuing.
REQ-022 SHALL hold byte_idx at 0 in IDLE and increment it at each byte's start bit.

Reset
REQ-023 SHALL, on reset, force state IDLE, tx=1, busy=0, done=0, byte_idx=0 and clear all buffer words to 0.
REQ-024 SHALL, on reset mid-frame, abort immediately with tx high on the next cycle and no done pulse.

Configuration
REQ-025 SHALL, with FRAME_CHECKSUM_EN defined, append byte 55 = XOR of bytes 0..54 (frame 56 bytes, byte_idx reaches 55, frame time 56*10*CLKS_PER_BIT).
REQ-026 SHALL, without FRAME_CHECKSUM_EN, send exactly 55 bytes with no checksum logic present.

Structure
REQ-027 SHALL place FRAME_BYTES=55, PAD_IDX=50, PAD_BYTE=8'h00, NUM_WORDS=27 and the word-index enumeration in package scene_frame_pkg, shared with the receiving side.
REQ-028 SHALL instantiate one sub-module uart_tx_byte (valid/ready byte serialiser owning the bit counter and baud counter); scene_frame_tx owns the buffer, byte sequencing and pad/checksum insertion.

Verification (bench uses CLKS_PER_BIT=4)
REQ-029 SHALL verify: write word0=16'h1234, word26=16'hBEEF, start -> bytes 0,1 = 34,12; bytes 53,54 = EF,BE; byte 50 = 00; tx low on cycle start+1.
REQ-030 SHALL verify: start at cycle 0 -> done pulses at cycle 2201, busy high cycles 1..2200 (2240 with FRAME_CHECKSUM_EN).
REQ-031 SHALL verify: wr_en of word5=16'hFFFF during busy plus second start during busy -> frame unchanged, exactly one done pulse.
REQ-032 SHALL verify: reset asserted at byte_idx=20 -> tx=1 and busy=0 next cycle, no done pulse, all words reread as 0 in the next frame.
REQ-033 SHALL verify: wr_addr=27 with wr_data=16'hAAAA -> buffer unchanged; simultaneous wr_en(word3=16'h0102)+start -> bytes 6,7 = 02,01.
REQ-034 SHALL verify with FRAME_CHECKSUM_EN: all words 0 except word0=16'h00FF -> byte 55 = FF.

Source files
------------

// File: rtl/scene_frame_pkg.sv
// Scene frame constants, word map and UART state encoding.
// Shared by the transmitter and the receiving side.
package scene_frame_pkg;

  localparam int FRAME_BYTES = 55;
  localparam int PAD_IDX = 50;
  localparam logic [7:0] PAD_BYTE = 8'h00;
  localparam int NUM_WORDS = 27;

`ifdef FRAME_CHECKSUM_EN
  localparam int TX_BYTES = FRAME_BYTES + 1;
`else
  localparam int TX_BYTES = FRAME_BYTES;
`endif

  typedef enum logic [4:0] {
    W_V0X, W_V0Y, W_V0Z,
    W_V1X, W_V1Y, W_V1Z,
    W_V2X, W_V2Y, W_V2Z,
    W_NX, W_NY, W_NZ,
    W_LX, W_LY, W_LZ,
    W_VP00, W_VP01, W_VP02, W_VP03,
    W_VP10, W_VP11, W_VP12, W_VP13,
    W_VP30, W_VP31, W_VP32, W_VP33
  } word_idx_e;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } tx_state_e;

endpackage

// File: rtl/scene_frame_tx_uart.sv
// uart_tx_byte: valid/ready 8N1 byte serialiser.
// Ports: clk, reset, i_valid, i_data[7:0], o_ready, o_tx.
// o_ready is high in IDLE and on the last stop-bit cycle, so a
// byte offered then starts its start bit on the very next cycle.
module uart_tx_byte
  import scene_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);

  tx_state_e   r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        w_bit_end;

  assign w_bit_end = (r_baud == 16'(CLKS_PER_BIT - 1));
  assign o_ready = (r_state == IDLE) ||
                   ((r_state == STOP_BIT) && w_bit_end);
  assign o_tx = r_tx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (i_valid) begin
            r_shift <= i_data;
            r_tx    <= 1'b0;
            r_state <= START_BIT;
          end
        end
        START_BIT: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA_BITS;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        DATA_BITS: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP_BIT;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        STOP_BIT: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (i_valid) begin
              r_shift <= i_data;
              r_tx    <= 1'b0;
              r_state <= START_BIT;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/scene_frame_tx.sv
// Scene frame transmitter: 27-word buffer sent as a UART byte frame.
// Ports: clk, reset, wr_en/wr_addr/wr_data (buffer write), start,
// busy, done, byte_idx, tx. Define FRAME_CHECKSUM_EN to append an
// XOR checksum byte after the 55 frame bytes.
module scene_frame_tx
  import scene_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [5:0]  byte_idx,
  output logic        tx
);

  logic [15:0] r_buf [NUM_WORDS];
  logic        r_busy;
  logic        r_done;
  logic [5:0]  r_byte_idx;

  logic        w_wr_ok;
  logic        w_valid;
  logic        w_ready;
  logic [5:0]  w_next_idx;
  logic [4:0]  w_sel;
  logic        w_hi;
  logic [15:0] w_word;
  logic [7:0]  w_byte;

  assign w_wr_ok = wr_en && !r_busy &&
                   (wr_addr < 5'(NUM_WORDS));
  assign w_valid = r_busy ?
                   (r_byte_idx != 6'(TX_BYTES - 1)) : start;
  assign w_next_idx = r_busy ? (r_byte_idx + 6'd1) : 6'd0;

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] w_fold;
  logic [7:0]  w_csum;

  always_comb begin
    w_fold = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      w_fold = w_fold ^ r_buf[i];
    end
    w_csum = w_fold[15:8] ^ w_fold[7:0];
  end
`endif

  // Bytes past the pad are shifted by one: 51/52 -> word 25.
  // A write landing with start is forwarded so byte 0 sees it.
  always_comb begin
    w_sel = '0;
    w_hi  = 1'b0;
    if (w_next_idx < 6'(PAD_IDX)) begin
      w_sel = w_next_idx[5:1];
      w_hi  = w_next_idx[0];
    end else begin
      w_sel = 5'((w_next_idx - 6'd1) >> 1);
      w_hi  = ~w_next_idx[0];
    end
    w_word = (w_sel < 5'(NUM_WORDS)) ? r_buf[w_sel] : '0;
    if (w_wr_ok && (wr_addr == w_sel)) begin
      w_word = wr_data;
    end
    w_byte = w_hi ? w_word[15:8] : w_word[7:0];
    if (w_next_idx == 6'(PAD_IDX)) begin
      w_byte = PAD_BYTE;
    end
`ifdef FRAME_CHECKSUM_EN
    if (w_next_idx == 6'(FRAME_BYTES)) begin
      w_byte = w_csum;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_byte_idx <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (w_wr_ok) begin
        r_buf[wr_addr] <= wr_data;
      end
      if (!r_busy) begin
        if (start) begin
          r_busy     <= 1'b1;
          r_byte_idx <= '0;
        end
      end else if (w_ready) begin
        if (w_valid) begin
          r_byte_idx <= r_byte_idx + 6'd1;
        end else begin
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_byte_idx <= '0;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk    (clk),
    .reset  (reset),
    .i_valid(w_valid),
    .i_data (w_byte),
    .o_ready(w_ready),
    .o_tx   (tx)
  );

  assign busy = r_busy;
  assign done = r_done;
  assign byte_idx = r_byte_idx;

endmodule

// File: tb/tb_scene_frame_tx.sv
// Bench for scene_frame_tx at CLKS_PER_BIT=4.
// Serial bytes are decoded and checked against a frame scoreboard.
module tb_scene_frame_tx;

  localparam int CPB = 4;
`ifdef FRAME_CHECKSUM_EN
  localparam int NB = 56;
`else
  localparam int NB = 55;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [5:0]  byte_idx;
  logic        tx;

  scene_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .byte_idx(byte_idx),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot = 0;

  logic [15:0] m_buf [27];
  logic [7:0]  q [$];
  logic [7:0]  rx [64];
  int          mon_cnt = 0;
  bit          mon_en = 1'b0;

  typedef struct {
    logic [4:0]  a;
    logic [15:0] d;
    int          bi;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic build_q();
    logic [7:0] x;
    q.delete();
    for (int k = 0; k < 25; k++) begin
      q.push_back(m_buf[k][7:0]);
      q.push_back(m_buf[k][15:8]);
    end
    q.push_back(8'h00);
    for (int k = 25; k < 27; k++) begin
      q.push_back(m_buf[k][7:0]);
      q.push_back(m_buf[k][15:8]);
    end
`ifdef FRAME_CHECKSUM_EN
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(x);
`endif
  endtask

  // Serial decoder: sample mid-bit, compare to the scoreboard.
  initial begin
    logic [7:0] b;
    logic       sb;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && tx == 1'b0) begin
        repeat (6) @(negedge clk);
        b[0] = tx;
        for (int i = 1; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = tx;
        end
        repeat (4) @(negedge clk);
        sb = tx;
        if (mon_en) begin
          if (q.size() == 0) begin
            chk("extra_byte", 1, 0);
          end else begin
            e = q.pop_front();
            chk($sformatf("byte%0d", mon_cnt), b, e);
          end
          chk($sformatf("stop%0d", mon_cnt), sb, 1);
          if (mon_cnt < 64) rx[mon_cnt] = b;
          mon_cnt++;
        end
      end
    end
  end

  task automatic write_word(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    if (a < 5'd27) m_buf[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_frame(input bit cw, input logic [4:0] wa,
                           input logic [15:0] wd,
                           input bit disturb, input bit rst_mid);
    int cyc;
    int dcyc;
    int nd;
    int blast;
    bit rst_done;
    cyc = 0;
    dcyc = -1;
    nd = 0;
    blast = 0;
    rst_done = 1'b0;
    mon_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    if (cw) begin
      wr_en = 1'b1;
      wr_addr = wa;
      wr_data = wd;
      if (wa < 5'd27) m_buf[wa] = wd;
    end
    build_q();
    mon_en = 1'b1;
    while (cyc < NB * 10 * CPB + 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        wr_en = 1'b0;
        chk("tx_low_c1", tx, 0);
        chk("busy_c1", busy, 1);
        chk("idx_c1", byte_idx, 0);
      end
      if (disturb && cyc == 100) begin
        wr_en = 1'b1;
        wr_addr = 5'd5;
        wr_data = 16'hFFFF;
        start = 1'b1;
      end
      if (disturb && cyc == 101) begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      if (busy) blast = cyc;
      if (done) begin
        nd++;
        if (dcyc < 0) dcyc = cyc;
      end
      if (!rst_mid && cyc == 1 + 10 * CPB)
        chk("idx_byte1", byte_idx, 1);
      if (!rst_mid && cyc == 1 + (NB - 1) * 10 * CPB)
        chk("idx_last", byte_idx, NB - 1);
      if (rst_mid && !rst_done && byte_idx == 6'd20) begin
        reset = 1'b1;
        mon_en = 1'b0;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        rst_done = 1'b1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", byte_idx, 0);
        for (int k = 0; k < 27; k++) m_buf[k] = '0;
        q.delete();
      end
    end
    mon_en = 1'b0;
    if (rst_mid) begin
      chk("rst_seen", rst_done, 1);
      chk("rst_ndone", nd, 0);
    end else begin
      chk("done_cycle", dcyc, NB * 10 * CPB + 1);
      chk("busy_last", blast, NB * 10 * CPB);
      chk("ndone", nd, 1);
      chk("nbytes", mon_cnt, NB);
      chk("q_empty", q.size(), 0);
    end
  endtask

  initial begin
    tbl[0] = '{5'd0, 16'h1234, 0, 8'h34, 8'h12};
    tbl[1] = '{5'd26, 16'hBEEF, 53, 8'hEF, 8'hBE};
    tbl[2] = '{5'd25, 16'hCAFE, 51, 8'hFE, 8'hCA};
    tbl[3] = '{5'd12, 16'h5A3C, 24, 8'h3C, 8'h5A};
    tbl[4] = '{5'd7, 16'h8001, 14, 8'h01, 8'h80};
    tbl[5] = '{5'd27, 16'hAAAA, -1, 8'h00, 8'h00};
    for (int k = 0; k < 27; k++) m_buf[k] = '0;

    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_idx", byte_idx, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) write_word(tbl[i].a, tbl[i].d);
    run_frame(1'b0, 5'd0, 16'h0, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      if (tbl[i].bi >= 0) begin
        chk($sformatf("tbl%0d_lo", i), rx[tbl[i].bi], tbl[i].lo);
        chk($sformatf("tbl%0d_hi", i), rx[tbl[i].bi + 1], tbl[i].hi);
      end
    end
    chk("pad50", rx[50], 8'h00);

    repeat (5) @(negedge clk);
    run_frame(1'b0, 5'd0, 16'h0, 1'b1, 1'b0);
    chk("busy_wr_ignored", rx[10], 8'h00);

    repeat (5) @(negedge clk);
    run_frame(1'b1, 5'd3, 16'h0102, 1'b0, 1'b0);
    chk("coinc_b6", rx[6], 8'h02);
    chk("coinc_b7", rx[7], 8'h01);

    repeat (5) @(negedge clk);
    run_frame(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    repeat (60) @(negedge clk);
    run_frame(1'b0, 5'd0, 16'h0, 1'b0, 1'b0);
    chk("cleared_b0", rx[0], 8'h00);
    chk("cleared_b54", rx[54], 8'h00);

`ifdef FRAME_CHECKSUM_EN
    repeat (5) @(negedge clk);
    run_frame(1'b1, 5'd0, 16'h00FF, 1'b0, 1'b0);
    chk("csum55", rx[55], 8'hFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
